missile_pool: RTL

Parametrised pool of CHANNELS independent missile slots for the VGA shooter, replacing the fixed five-missile enemy wiring and the single player missile with one reusable block. It accepts fire requests, allocates the lowest free slot, moves every live missile once per frame, and retires missiles that leave the playfield or are reported hit. It sits beside each `draw_ship` and enemy cluster. Its packed position and active buses feed the drawing stages and collision logic, all in the `pclk` domain.

---
 rtl/missile_pkg.sv | 17 +
 rtl/missile_alloc.sv | 23 ++
 rtl/missile_pool.sv | 131 +++++++++++++
 3 files changed

// File: rtl/missile_pkg.sv
// Shared constants and helpers for the missile pool: screen size, default
// coordinate width, direction codes and packed-bus slot addressing.
package missile_pkg;

  localparam int SCREEN_H   = 1024;
  localparam int SCREEN_V   = 768;
  localparam int XW_DEFAULT = 11;

  localparam int DIR_UP   = 0;
  localparam int DIR_DOWN = 1;

  // LSB of slot idx inside a packed bus of w-bit fields
  function automatic int slot_lsb(input int idx, input int w);
    return idx * w;
  endfunction

endpackage

// File: rtl/missile_alloc.sv
// Lowest-index free slot finder for the missile pool (purely combinational).
module missile_alloc #(
  parameter int CHANNELS = 5,
  parameter int IW       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic [CHANNELS-1:0] active,
  output logic [IW-1:0]       grant,
  output logic                any_free
);

  // Scan from the top so the lowest free index is the last one written.
  always_comb begin
    grant    = '0;
    any_free = 1'b0;
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      if (!active[i]) begin
        grant    = IW'(i);
        any_free = 1'b1;
      end
    end
  end

endmodule

// File: rtl/missile_pool.sv
// Pool of CHANNELS missile slots: allocate on fire, move once per frame, retire
// on bound or hit. Define MISSILE_POOL_AUTOFIRE_EN to re-fire while fire_req is held.
module missile_pool
  import missile_pkg::*;
#(
  parameter int CHANNELS = 5,
  parameter int XW       = XW_DEFAULT,
  parameter int SPEED    = 4,
  parameter int COOLDOWN = 16,
  parameter int DIR      = DIR_UP,
  parameter int Y_MIN    = 0,
  parameter int Y_MAX    = 768
) (
  input  logic                           pclk,
  input  logic                           rst,
  input  logic                           vsync_in,
  input  logic                           fire_req,
  input  logic [XW-1:0]                  fire_x,
  input  logic [XW-1:0]                  fire_y,
  output logic                           fire_ack,
  input  logic [CHANNELS-1:0]            hit_in,
  output logic [CHANNELS*XW-1:0]         x_out,
  output logic [CHANNELS*XW-1:0]         y_out,
  output logic [CHANNELS-1:0]            active_out,
  output logic [$clog2(CHANNELS+1)-1:0]  count_out
);

  localparam int IW  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int CW  = $clog2(CHANNELS + 1);
  localparam int CDW = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;

  localparam logic [XW:0] SPEED_W = (XW+1)'(SPEED);
  localparam logic [XW:0] YMIN_W  = (XW+1)'(Y_MIN);
  localparam logic [XW:0] YMAX_W  = (XW+1)'(Y_MAX);

  logic                   vsync_q;
  logic                   tick_q;
  logic                   fire_cond;
  logic                   accept;
  logic                   any_free;
  logic [IW-1:0]          grant;
  logic [CDW-1:0]         cooldown;
  logic [CHANNELS-1:0]    active_nxt;
  logic [CHANNELS*XW-1:0] x_nxt;
  logic [CHANNELS*XW-1:0] y_nxt;
  logic [CW-1:0]          count_nxt;
  logic [XW:0]            y_ext;
  logic [XW:0]            y_mv;

  missile_alloc #(
    .CHANNELS (CHANNELS),
    .IW       (IW)
  ) u_alloc (
    .active   (active_out),
    .grant    (grant),
    .any_free (any_free)
  );

`ifdef MISSILE_POOL_AUTOFIRE_EN
  assign fire_cond = fire_req;
`else
  logic fire_q;

  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) fire_q <= 1'b0;
    else      fire_q <= fire_req;
  end

  assign fire_cond = fire_req & ~fire_q;
`endif

  assign accept = fire_cond & (cooldown == '0) & any_free;

  // Hit beats move; allocation sees only slots free before this cycle's updates.
  always_comb begin
    active_nxt = active_out;
    x_nxt      = x_out;
    y_nxt      = y_out;
    y_ext      = '0;
    y_mv       = '0;
    count_nxt  = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      y_ext = {1'b0, y_out[slot_lsb(i, XW) +: XW]};
      if (hit_in[i]) begin
        active_nxt[i] = 1'b0;
      end else if (tick_q && active_out[i]) begin
        if (DIR == DIR_DOWN) begin
          y_mv = y_ext + SPEED_W;
          if (y_mv >= YMAX_W) active_nxt[i] = 1'b0;
          else                y_nxt[slot_lsb(i, XW) +: XW] = y_mv[XW-1:0];
        end else begin
          y_mv = y_ext - SPEED_W;
          if (y_ext < YMIN_W + SPEED_W) active_nxt[i] = 1'b0;
          else                          y_nxt[slot_lsb(i, XW) +: XW] = y_mv[XW-1:0];
        end
      end
    end
    if (accept) begin
      active_nxt[grant]                       = 1'b1;
      x_nxt[slot_lsb(int'(grant), XW) +: XW]  = fire_x;
      y_nxt[slot_lsb(int'(grant), XW) +: XW]  = fire_y;
    end
    for (int i = 0; i < CHANNELS; i++) begin
      count_nxt = count_nxt + CW'(active_nxt[i]);
    end
  end

  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      vsync_q    <= 1'b0;
      tick_q     <= 1'b0;
      cooldown   <= '0;
      fire_ack   <= 1'b0;
      active_out <= '0;
      x_out      <= '0;
      y_out      <= '0;
      count_out  <= '0;
    end else begin
      vsync_q    <= vsync_in;
      tick_q     <= vsync_in & ~vsync_q;
      fire_ack   <= accept;
      active_out <= active_nxt;
      x_out      <= x_nxt;
      y_out      <= y_nxt;
      count_out  <= count_nxt;
      if (accept)                         cooldown <= CDW'(COOLDOWN);
      else if (tick_q && cooldown != '0)  cooldown <= cooldown - CDW'(1);
    end
  end

endmodule
